lane_deserializer: RTL and testbench

LANE_DESERIALIZER -- requirements
Module: lane_deserializer

---
 rtl/lane_deserializer_pkg.sv | 13 +
 rtl/lane_deserializer.sv | 105 ++++++++++
 tb/tb_lane_deserializer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/lane_deserializer_pkg.sv
// rtl/lane_deserializer_pkg.sv - shared phy symbol constants and lane FSM state encoding
package lane_deserializer_pkg;

    localparam logic [7:0] COM_SYM  = 8'hBC;
    localparam logic [7:0] IDLE_SYM = 8'h7C;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } lane_state_t;

endpackage

// File: rtl/lane_deserializer.sv
// rtl/lane_deserializer.sv - serial lane to byte deserializer with COM-based alignment
module lane_deserializer
    import lane_deserializer_pkg::*;
#(
    parameter logic [7:0] COM        = COM_SYM,
    parameter logic [7:0] IDLE       = IDLE_SYM,
    parameter int         SYNC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam logic [3:0] SYNC_LIM = 4'(SYNC_COUNT);

    lane_state_t state, state_nxt;
    logic [6:0]  sr;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [2:0]  com_cnt, com_cnt_nxt;
    logic [7:0]  data_nxt;
    logic        valid_nxt;
    logic        active_nxt;

    logic [7:0]  word;
    logic        boundary;
    logic [3:0]  com_inc;

    // Candidate byte ends with the bit being sampled on this edge.
    assign word     = {sr, data_in};
    assign boundary = (bit_cnt == 3'd7);
    assign com_inc  = {1'b0, com_cnt} + 4'd1;

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= ST_HUNT;
            sr        <= 7'd0;
            bit_cnt   <= 3'd0;
            com_cnt   <= 3'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= word[6:0];
            bit_cnt   <= bit_cnt_nxt;
            com_cnt   <= com_cnt_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
            active    <= active_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        com_cnt_nxt = com_cnt;
        data_nxt    = data_out;
        valid_nxt   = valid_out;
        active_nxt  = active;
        case (state)
            ST_HUNT: begin
                valid_nxt = 1'b0;
                if (word == COM) begin
                    bit_cnt_nxt = 3'd0;
                    com_cnt_nxt = 3'd1;
                    state_nxt   = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                valid_nxt   = 1'b0;
                bit_cnt_nxt = bit_cnt + 3'd1;
                if (boundary) begin
                    if (word == COM) begin
                        if (com_inc <= SYNC_LIM) begin
                            com_cnt_nxt = com_inc[2:0];
                        end
                        if (com_inc >= SYNC_LIM) begin
                            state_nxt  = ST_ACTIVE;
                            active_nxt = 1'b1;
                        end
                    end else begin
                        // The failing byte is dropped; hunting resumes on later windows.
                        state_nxt   = ST_HUNT;
                        com_cnt_nxt = 3'd0;
                    end
                end
            end
            ST_ACTIVE: begin
                bit_cnt_nxt = bit_cnt + 3'd1;
                active_nxt  = 1'b1;
                if (boundary) begin
                    data_nxt  = word;
                    valid_nxt = (word != COM) && (word != IDLE);
                end
            end
            default: begin
                state_nxt = ST_HUNT;
            end
        endcase
    end

endmodule

// File: tb/tb_lane_deserializer.sv
// tb/tb_lane_deserializer.sv - self-checking bench for lane_deserializer
module tb_lane_deserializer;

    logic       clk_32f = 1'b0;
    logic       reset_L;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int vectors = 0;
    int errors  = 0;

    lane_deserializer dut (
        .clk_32f  (clk_32f),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active)
    );

    always #5 clk_32f = ~clk_32f;

    // Reference model: bit history since reset, alignment anchored at a bit index.
    bit         hist[$];
    int         m_mode;
    int         m_n;
    int         m_anchor;
    int         m_coms;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_act;

    task automatic model_reset();
        hist.delete();
        m_mode   = 0;
        m_n      = 0;
        m_anchor = 0;
        m_coms   = 0;
        m_data   = 8'h00;
        m_valid  = 1'b0;
        m_act    = 1'b0;
    endtask

    task automatic model_bit(input logic b);
        logic [7:0] w;
        bit         at_byte;
        hist.push_back(b);
        m_n++;
        w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (m_n - 8 + i >= 0) w[7-i] = hist[m_n-8+i];
        end
        at_byte = ((m_n - m_anchor) % 8) == 0;
        if (m_mode == 0) begin
            m_valid = 1'b0;
            if (w == 8'hBC) begin
                m_mode   = 1;
                m_anchor = m_n;
                m_coms   = 1;
            end
        end else if (m_mode == 1) begin
            m_valid = 1'b0;
            if (at_byte) begin
                if (w == 8'hBC) begin
                    m_coms++;
                    if (m_coms >= 4) begin
                        m_mode = 2;
                        m_act  = 1'b1;
                    end
                end else begin
                    m_mode = 0;
                    m_coms = 0;
                end
            end
        end else if (at_byte) begin
            m_data  = w;
            m_valid = (w != 8'hBC) && (w != 8'h7C);
        end
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        model_bit(b);
        check("data_out", data_out, m_data);
        check("valid_out", {7'd0, valid_out}, {7'd0, m_valid});
        check("active", {7'd0, active}, {7'd0, m_act});
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic apply_reset();
        reset_L = 1'b0;
        #1;
        model_reset();
        check("rst_data", data_out, 8'h00);
        check("rst_valid", {7'd0, valid_out}, 8'h00);
        check("rst_active", {7'd0, active}, 8'h00);
        @(posedge clk_32f);
        #1;
        reset_L = 1'b1;
        data_in = 1'b0;
    endtask

    initial begin
        logic [7:0] rb;
        int         nj;
        reset_L = 1'b0;
        data_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_32f);
        #1;
        apply_reset();

        // Four aligned commas bring the lane up on the last bit of the fourth.
        repeat (3) send_byte(8'hBC);
        for (int i = 7; i >= 1; i--) send_bit(rb_bc(i));
        check("pre_active", {7'd0, active}, 8'h00);
        send_bit(1'b0);
        check("sync_active", {7'd0, active}, 8'h01);
        check("sync_valid", {7'd0, valid_out}, 8'h00);

        // Junk lead-in, sync, then payload held for a full byte period.
        apply_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (4) send_byte(8'hBC);
        check("junk_active", {7'd0, active}, 8'h01);
        send_byte(8'hA5);
        check("a5_data", data_out, 8'hA5);
        check("a5_valid", {7'd0, valid_out}, 8'h01);
        rb = 8'h7C;
        for (int i = 7; i >= 1; i--) begin
            send_bit(rb[i]);
            check("a5_hold", data_out, 8'hA5);
            check("a5_hold_valid", {7'd0, valid_out}, 8'h01);
        end
        send_bit(rb[0]);
        check("idle_valid", {7'd0, valid_out}, 8'h00);
        send_byte(8'hBC);
        check("com_valid", {7'd0, valid_out}, 8'h00);
        send_byte(8'h12);
        check("p12_data", data_out, 8'h12);
        check("p12_valid", {7'd0, valid_out}, 8'h01);

        // Comma straddling a byte boundary does not realign the stream.
        send_byte(8'h05);
        check("shift_a", data_out, 8'h05);
        send_byte(8'hE0);
        check("shift_b", data_out, 8'hE0);
        check("shift_valid", {7'd0, valid_out}, 8'h01);

        for (int i = 0; i < 24; i++) send_byte(8'($urandom_range(0, 255)));

        // Mid-byte reset in ACTIVE; afterwards comma-free data never syncs.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            send_byte(8'($urandom_range(0, 15)));
            check("nosync_active", {7'd0, active}, 8'h00);
        end

        // Broken comma run falls back to HUNT and needs a fresh four.
        apply_reset();
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h3C);
        check("broken_active", {7'd0, active}, 8'h00);
        repeat (3) send_byte(8'hBC);
        check("resync_pre", {7'd0, active}, 8'h00);
        send_byte(8'hBC);
        check("resync_active", {7'd0, active}, 8'h01);

        // Randomized lead-in and payload against the model.
        apply_reset();
        nj = $urandom_range(0, 12);
        for (int i = 0; i < nj; i++) send_bit(1'($urandom_range(0, 1)));
        repeat (4) send_byte(8'hBC);
        for (int i = 0; i < 40; i++) send_byte(8'($urandom_range(0, 255)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    function automatic logic rb_bc(input int idx);
        logic [7:0] v;
        v = 8'hBC;
        return v[idx];
    endfunction

endmodule
